// File: rtl/alu_shift_sequencer_if.sv
// rtl/alu_shift_sequencer_if.sv - request/response bundle between control unit and execute block
interface alu_shift_sequencer_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               start;
    logic [3:0]         op;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [SHAMT_W-1:0] shamt;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   result;
    logic               zero;
    logic               overflow;
    logic               branch_taken;

    modport master (
        output start, op, a, b, shamt,
        input  busy, done, result, zero, overflow, branch_taken
    );

    modport slave (
        input  start, op, a, b, shamt,
        output busy, done, result, zero, overflow, branch_taken
    );
endinterface

// File: rtl/alu_shift_sequencer.sv
// rtl/alu_shift_sequencer.sv - multicycle ALU with iterative shifter and branch evaluation
module alu_shift_sequencer #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int STEP    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_shift_sequencer_if.slave bus
);
    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [SHAMT_W-1:0] STEP_L = SHAMT_W'(STEP);
    localparam logic [SHAMT_W-1:0] HALF_L = SHAMT_W'(WIDTH / 2);

    state_t             state, state_n;
    logic [WIDTH-1:0]   shreg, shreg_n, result_q, result_n;
    logic [SHAMT_W-1:0] rem, rem_n;
    logic [3:0]         op_q, op_n;
    logic               sign_q, sign_n;
    logic               busy_q, busy_n, done_q, done_n;
    logic               zero_q, zero_n, ovf_q, ovf_n, br_q, br_n;

    logic [WIDTH-1:0]   sum, diff, alu_res, operand, shifted;
    logic               alu_ovf, alu_br, is_shift;
    logic [SHAMT_W-1:0] amt, step_amt;

    assign sum  = bus.a + bus.b;
    assign diff = bus.a - bus.b;

    always_comb begin
        alu_res  = '0;
        alu_ovf  = 1'b0;
        alu_br   = 1'b0;
        is_shift = 1'b0;
        amt      = '0;
        case (bus.op)
            4'd0:  alu_res = bus.a;
            4'd1: begin
                alu_res = sum;
                alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            4'd2: begin
                alu_res = diff;
                alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            4'd3:  alu_res = bus.a & bus.b;
            4'd4:  alu_res = bus.b;
            4'd5, 4'd7, 4'd8: begin
                is_shift = 1'b1;
                amt      = bus.shamt;
            end
            4'd6, 4'd9: begin
                is_shift = 1'b1;
                amt      = bus.b[SHAMT_W-1:0];
            end
            4'd10: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            4'd11: begin alu_res = diff; alu_br = (bus.a == bus.b); end
            4'd12: begin alu_res = diff; alu_br = (bus.a != bus.b); end
            4'd13: begin alu_res = diff; alu_br = ($signed(bus.a) <= $signed(bus.b)); end
            4'd14: begin alu_res = diff; alu_br = ($signed(bus.a) > $signed(bus.b)); end
            default: begin
                is_shift = 1'b1;
                amt      = HALF_L;
            end
        endcase
    end

    assign operand  = (bus.op == 4'd15) ? bus.b : bus.a;
    assign step_amt = (rem < STEP_L) ? rem : STEP_L;

    // Arithmetic right shifts fill with the sign captured at accept, not the live shreg MSB
    always_comb begin
        case (op_q)
            4'd7:       shifted = shreg >> step_amt;
            4'd8, 4'd9: shifted = (shreg >> step_amt) |
                                  (sign_q ? ~({WIDTH{1'b1}} >> step_amt) : {WIDTH{1'b0}});
            default:    shifted = shreg << step_amt;
        endcase
    end

    always_comb begin
        state_n  = state;
        shreg_n  = shreg;
        rem_n    = rem;
        op_n     = op_q;
        sign_n   = sign_q;
        busy_n   = busy_q;
        done_n   = 1'b0;
        result_n = result_q;
        zero_n   = zero_q;
        ovf_n    = ovf_q;
        br_n     = br_q;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    op_n   = bus.op;
                    sign_n = bus.a[WIDTH-1];
                    if (!is_shift) begin
                        result_n = alu_res;
                        zero_n   = (alu_res == '0);
                        ovf_n    = alu_ovf;
                        br_n     = alu_br;
                        done_n   = 1'b1;
                    end else if (amt == '0) begin
                        result_n = operand;
                        zero_n   = (operand == '0);
                        ovf_n    = 1'b0;
                        br_n     = 1'b0;
                        done_n   = 1'b1;
                    end else begin
                        shreg_n = operand;
                        rem_n   = amt;
                        busy_n  = 1'b1;
                        state_n = SHIFT;
                    end
                end
            end
            SHIFT: begin
                shreg_n = shifted;
                rem_n   = rem - step_amt;
                if (rem == step_amt) begin
                    result_n = shifted;
                    zero_n   = (shifted == '0);
                    ovf_n    = 1'b0;
                    br_n     = 1'b0;
                    done_n   = 1'b1;
                    busy_n   = 1'b0;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            shreg    <= '0;
            rem      <= '0;
            op_q     <= '0;
            sign_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            br_q     <= 1'b0;
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            rem      <= rem_n;
            op_q     <= op_n;
            sign_q   <= sign_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
            result_q <= result_n;
            zero_q   <= zero_n;
            ovf_q    <= ovf_n;
            br_q     <= br_n;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.result       = result_q;
    assign bus.zero         = zero_q;
    assign bus.overflow     = ovf_q;
    assign bus.branch_taken = br_q;
endmodule

// File: tb/tb_alu_shift_sequencer.sv
// tb/tb_alu_shift_sequencer.sv - directed vector bench for alu_shift_sequencer (STEP=1 and STEP=4)
module tb_alu_shift_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start1 = 1'b0, start4 = 1'b0;
    logic [3:0]  op_s = '0;
    logic [31:0] a_s = '0, b_s = '0;
    logic [4:0]  sh_s = '0;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    alu_shift_sequencer_if #(.WIDTH(32), .SHAMT_W(5)) i1 ();
    alu_shift_sequencer_if #(.WIDTH(32), .SHAMT_W(5)) i4 ();

    assign i1.start = start1;
    assign i1.op    = op_s;
    assign i1.a     = a_s;
    assign i1.b     = b_s;
    assign i1.shamt = sh_s;
    assign i4.start = start4;
    assign i4.op    = op_s;
    assign i4.a     = a_s;
    assign i4.b     = b_s;
    assign i4.shamt = sh_s;

    alu_shift_sequencer #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) dut1 (.clk(clk), .reset(reset), .bus(i1));
    alu_shift_sequencer #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) dut4 (.clk(clk), .reset(reset), .bus(i4));

    typedef struct {
        string       name;
        logic        sel;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] res;
        logic        z;
        logic        o;
        logic        br;
        int          lat;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int cyc, bcnt;
        logic d, bz;
        logic [31:0] r;
        logic zz, oo, bb;
        cyc = 0; bcnt = 0;
        @(posedge clk); #1;
        op_s = v.op; a_s = v.a; b_s = v.b; sh_s = v.sh;
        if (v.sel) start4 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start4 = 1'b0;
        d = 1'b0;
        while (!d && cyc < 100) begin
            @(negedge clk);
            cyc++;
            d  = v.sel ? i4.done : i1.done;
            bz = v.sel ? i4.busy : i1.busy;
            if (!d && bz) bcnt++;
        end
        r  = v.sel ? i4.result : i1.result;
        zz = v.sel ? i4.zero : i1.zero;
        oo = v.sel ? i4.overflow : i1.overflow;
        bb = v.sel ? i4.branch_taken : i1.branch_taken;
        chk({v.name, "_latency"}, cyc, v.lat);
        chk({v.name, "_busy_cycles"}, bcnt, v.lat - 1);
        chk({v.name, "_result"}, r, v.res);
        chk({v.name, "_zero"}, 32'(zz), 32'(v.z));
        chk({v.name, "_overflow"}, 32'(oo), 32'(v.o));
        chk({v.name, "_branch"}, 32'(bb), 32'(v.br));
        @(negedge clk);
        chk({v.name, "_done_pulse"}, 32'(v.sel ? i4.done : i1.done), 32'd0);
    endtask

    initial begin
        tv.push_back('{"add_ovf", 1'b0, 4'd1,  32'h7FFFFFFF, 32'h1,        5'd0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1});
        tv.push_back('{"sub_eq",  1'b0, 4'd2,  32'd5,        32'd5,        5'd0, 32'h0,        1'b1, 1'b0, 1'b0, 1});
        tv.push_back('{"sub_ovf", 1'b0, 4'd2,  32'h80000000, 32'h1,        5'd0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1});
        tv.push_back('{"ble",     1'b0, 4'd13, 32'hFFFFFFFD, 32'd2,        5'd0, 32'hFFFFFFFB, 1'b0, 1'b0, 1'b1, 1});
        tv.push_back('{"beq",     1'b0, 4'd11, 32'd7,        32'd7,        5'd0, 32'h0,        1'b1, 1'b0, 1'b1, 1});
        tv.push_back('{"bne",     1'b0, 4'd12, 32'd7,        32'd7,        5'd0, 32'h0,        1'b1, 1'b0, 1'b0, 1});
        tv.push_back('{"bgt",     1'b0, 4'd14, 32'd1,        32'hFFFFFFFF, 5'd0, 32'h2,        1'b0, 1'b0, 1'b1, 1});
        tv.push_back('{"and",     1'b0, 4'd3,  32'hF0F0,     32'hFF00,     5'd0, 32'hF000,     1'b0, 1'b0, 1'b0, 1});
        tv.push_back('{"pass_b",  1'b0, 4'd4,  32'h1,        32'hDEAD,     5'd0, 32'hDEAD,     1'b0, 1'b0, 1'b0, 1});
        tv.push_back('{"pass_a",  1'b0, 4'd0,  32'h0,        32'h55,       5'd0, 32'h0,        1'b1, 1'b0, 1'b0, 1});
        tv.push_back('{"slt",     1'b0, 4'd10, 32'hFFFFFFFF, 32'h0,        5'd0, 32'h1,        1'b0, 1'b0, 1'b0, 1});
        tv.push_back('{"sll0",    1'b0, 4'd5,  32'hA5,       32'h0,        5'd0, 32'hA5,       1'b0, 1'b0, 1'b0, 1});
        tv.push_back('{"srl8",    1'b0, 4'd7,  32'hFF,       32'h0,        5'd8, 32'h0,        1'b1, 1'b0, 1'b0, 9});
        tv.push_back('{"sra_pos", 1'b0, 4'd8,  32'h40000000, 32'h0,        5'd3, 32'h08000000, 1'b0, 1'b0, 1'b0, 4});
        tv.push_back('{"lui1",    1'b0, 4'd15, 32'h0,        32'hFFFF1234, 5'd0, 32'h12340000, 1'b0, 1'b0, 1'b0, 17});
        tv.push_back('{"sllv4",   1'b1, 4'd6,  32'h1,        32'd9,        5'd0, 32'h00000200, 1'b0, 1'b0, 1'b0, 4});
        tv.push_back('{"lui4",    1'b1, 4'd15, 32'h0,        32'h1234,     5'd0, 32'h12340000, 1'b0, 1'b0, 1'b0, 5});
        tv.push_back('{"srav4",   1'b1, 4'd9,  32'h80000000, 32'h25,       5'd0, 32'hFC000000, 1'b0, 1'b0, 1'b0, 3});

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_busy", 32'(i1.busy), 32'd0);
        chk("reset_done", 32'(i1.done), 32'd0);
        chk("reset_result", i1.result, 32'h0);
        chk("reset_flags", {29'd0, i1.zero, i1.overflow, i1.branch_taken}, 32'd0);

        for (int i = 0; i < tv.size(); i++) run_vec(tv[i]);

        // back-to-back SUB then BLE: done on consecutive cycles
        @(posedge clk); #1;
        op_s = 4'd2; a_s = 32'd5; b_s = 32'd5; start1 = 1'b1;
        @(posedge clk); #1;
        op_s = 4'd13; a_s = 32'hFFFFFFFD; b_s = 32'd2;
        @(negedge clk);
        chk("b2b_done1", 32'(i1.done), 32'd1);
        chk("b2b_result1", i1.result, 32'h0);
        chk("b2b_zero1", 32'(i1.zero), 32'd1);
        @(posedge clk); #1;
        start1 = 1'b0;
        @(negedge clk);
        chk("b2b_done2", 32'(i1.done), 32'd1);
        chk("b2b_result2", i1.result, 32'hFFFFFFFB);
        chk("b2b_branch2", 32'(i1.branch_taken), 32'd1);

        // SRA with inputs and start toggled mid-shift
        @(posedge clk); #1;
        op_s = 4'd8; a_s = 32'h80000010; sh_s = 5'd4; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        begin
            int done_at, done_cnt;
            done_at = 0; done_cnt = 0;
            for (int k = 1; k <= 8; k++) begin
                @(negedge clk);
                if (i1.done) begin
                    done_cnt++;
                    if (done_at == 0) done_at = k;
                end
                if (k == 2) begin
                    a_s = 32'h12345678; op_s = 4'd1; sh_s = 5'd1; start1 = 1'b1;
                end
                if (k == 3) start1 = 1'b0;
                if (k == 5) chk("sra_mid_result", i1.result, 32'hF8000001);
            end
            chk("sra_mid_latency", done_at, 5);
            chk("sra_mid_done_count", done_cnt, 1);
        end

        // reset during the third SHIFT cycle of SRL 0xFF by 8
        @(posedge clk); #1;
        op_s = 4'd7; a_s = 32'hFF; sh_s = 5'd8; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid_busy_before", 32'(i1.busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", 32'(i1.busy), 32'd0);
        chk("rst_mid_done", 32'(i1.done), 32'd0);
        chk("rst_mid_result", i1.result, 32'h0);
        chk("rst_mid_flags", {29'd0, i1.zero, i1.overflow, i1.branch_taken}, 32'd0);
        reset = 1'b0;
        begin
            int dcnt;
            dcnt = 0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (i1.done) dcnt++;
            end
            chk("rst_mid_no_done", dcnt, 0);
        end
        run_vec('{"add_after_rst", 1'b0, 4'd1, 32'd2, 32'd3, 5'd0, 32'd5, 1'b0, 1'b0, 1'b0, 1});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
